// File: rtl/aquila_axi_pkg.sv
// Shared AXI4-Lite response codes and the device-bridge FSM encoding.
package aquila_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_DONE
    } bridge_state_e;

    // Any non-OKAY code (including EXOKAY, which a Lite slave must not send) is an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/device_axil_bridge.sv
// Single-transaction bridge from the core's strobe/ready device port to an AXI4-Lite master.
// Every output comes straight from a flop; the next values are computed in one always_comb.
module device_axil_bridge
    import aquila_axi_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                S_DEVICE_strobe_i,
    input  logic [XLEN-1:0]     S_DEVICE_addr_i,
    input  logic                S_DEVICE_rw_i,
    input  logic [XLEN/8-1:0]   S_DEVICE_byte_enable_i,
    input  logic [XLEN-1:0]     S_DEVICE_data_i,
    output logic                S_DEVICE_data_ready_o,
    output logic [XLEN-1:0]     S_DEVICE_data_o,
    output logic [XLEN-1:0]     m_axi_awaddr,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [XLEN-1:0]     m_axi_wdata,
    output logic [XLEN/8-1:0]   m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [XLEN-1:0]     m_axi_araddr,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [XLEN-1:0]     m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    output logic                err_o
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;

    bridge_state_e       state_q, state_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [XLEN/8-1:0]   be_q, be_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout;

    // The counter reads k-1 in the k-th busy cycle, so TIMEOUT_CYCLES-1 is the last cycle allowed.
    assign timeout = (state_q inside {ST_WR, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA}) &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        err_d     = err_q;
        cnt_d     = (state_q != ST_IDLE) ? cnt_q + CNT_W'(1) : cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (S_DEVICE_strobe_i) begin
                    addr_d  = S_DEVICE_addr_i;
                    wdata_d = S_DEVICE_data_i;
                    be_d    = S_DEVICE_byte_enable_i;
                    cnt_d   = '0;
                    if (S_DEVICE_rw_i) begin
                        state_d   = ST_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WR: begin
                // AW and W retire independently; either may finish first or both together.
                awvalid_d = awvalid_q & ~m_axi_awready;
                wvalid_d  = wvalid_q & ~m_axi_wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (m_axi_bvalid) begin
                    state_d  = ST_DONE;
                    bready_d = 1'b0;
                    if (resp_is_err(m_axi_bresp)) err_d = 1'b1;
                end
            end
            ST_RD_ADDR: begin
                if (m_axi_arready) begin
                    state_d   = ST_RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (m_axi_rvalid) begin
                    state_d  = ST_DONE;
                    rready_d = 1'b0;
                    rdata_d  = m_axi_rdata;
                    if (resp_is_err(m_axi_rresp)) err_d = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // A transaction that completes on its final allowed cycle is reported normally.
        if (timeout && state_d != ST_DONE) begin
            state_d   = ST_DONE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            rdata_d   = '0;
            err_d     = 1'b1;
        end

        if (S_DEVICE_strobe_i && state_q != ST_IDLE) err_d = 1'b1;

        ready_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign S_DEVICE_data_ready_o = ready_q;
    assign S_DEVICE_data_o       = rdata_q;
    assign m_axi_awaddr          = addr_q;
    assign m_axi_araddr          = addr_q;
    assign m_axi_wdata           = wdata_q;
    assign m_axi_wstrb           = be_q;
    assign m_axi_awvalid         = awvalid_q;
    assign m_axi_wvalid          = wvalid_q;
    assign m_axi_bready          = bready_q;
    assign m_axi_arvalid         = arvalid_q;
    assign m_axi_rready          = rready_q;
    assign err_o                 = err_q;

endmodule

// File: tb/tb_device_axil_bridge.sv
// Directed bench for device_axil_bridge: write/read latency, handshake ordering, errors, timeout, reset.
module tb_device_axil_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        strobe;
    logic [31:0] addr;
    logic        rw;
    logic [3:0]  be;
    logic [31:0] wdat;
    logic        dready;
    logic [31:0] dout;
    logic [31:0] awaddr, wdata_o, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, err;
    logic [1:0]  bresp, rresp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    device_axil_bridge #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .S_DEVICE_strobe_i(strobe), .S_DEVICE_addr_i(addr), .S_DEVICE_rw_i(rw),
        .S_DEVICE_byte_enable_i(be), .S_DEVICE_data_i(wdat),
        .S_DEVICE_data_ready_o(dready), .S_DEVICE_data_o(dout),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata_o), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .err_o(err)
    );

    // Advance one cycle; sample/drive 1 time unit after the edge. Strobe is a one-cycle pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        strobe = 1'b0;
    endtask

    task automatic slave_idle();
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
        arready = 0; rvalid = 0; rresp = 2'b00; rdata = '0;
    endtask

    task automatic request(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        strobe = 1'b1; rw = w; addr = a; be = b; wdat = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        if ({awvalid, wvalid, bready, arvalid, rready, dready, err} !== 7'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0000000", {awvalid, wvalid, bready, arvalid, rready, dready, err});
        end
        checks++;
        if (dout !== 32'h0) begin
            failures++; $display("FAIL reset_data got=%h exp=00000000", dout);
        end
        checks++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_fast();
        slave_idle();
        awready = 1; wready = 1; bvalid = 1;
        request(1'b1, 32'hC000_0010, 4'b0011, 32'hA5A5_1234);
        tick();  // N+1
        if ({awvalid, wvalid, dready} !== 3'b110) begin
            failures++; $display("FAIL wf_valid_n1 got=%b exp=110", {awvalid, wvalid, dready});
        end
        checks++;
        if (awaddr !== 32'hC000_0010 || wstrb !== 4'b0011 || wdata_o !== 32'hA5A5_1234) begin
            failures++; $display("FAIL wf_payload got=%h/%b/%h exp=c0000010/0011/a5a51234", awaddr, wstrb, wdata_o);
        end
        checks++;
        tick();  // N+2
        if ({awvalid, wvalid, bready, dready} !== 4'b0010) begin
            failures++; $display("FAIL wf_n2 got=%b exp=0010", {awvalid, wvalid, bready, dready});
        end
        checks++;
        tick();  // N+3
        if ({dready, bready, err} !== 3'b100) begin
            failures++; $display("FAIL wf_ready_n3 got=%b exp=100", {dready, bready, err});
        end
        checks++;
        slave_idle();
        tick();  // N+4
        if (dready !== 1'b0) begin
            failures++; $display("FAIL wf_pulse_len got=%b exp=0", dready);
        end
        checks++;
    endtask

    task automatic test_read_delay();
        int arv_cnt = 0;
        int rdy_cnt = 0;
        slave_idle();
        rvalid = 1; rdata = 32'h1122_3344;
        request(1'b0, 32'hC000_0020, 4'b0000, 32'h0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (arvalid) arv_cnt++;
            if (dready) rdy_cnt++;
            if (c == 1 && araddr !== 32'hC000_0020) begin
                failures++; $display("FAIL rd_araddr got=%h exp=c0000020", araddr);
            end
            if (c == 1) checks++;
            arready = (c == 6);
            if (c == 8) begin
                if (dready !== 1'b1 || dout !== 32'h1122_3344) begin
                    failures++; $display("FAIL rd_ready_data got=%b/%h exp=1/11223344", dready, dout);
                end
                checks++;
            end
        end
        if (arv_cnt !== 6) begin
            failures++; $display("FAIL rd_arvalid_cycles got=%0d exp=6", arv_cnt);
        end
        checks++;
        if (rdy_cnt !== 1) begin
            failures++; $display("FAIL rd_ready_count got=%0d exp=1", rdy_cnt);
        end
        checks++;
        slave_idle();
        tick();
    endtask

    task automatic test_write_split();
        int awv_cnt = 0;
        int b_hs = 0;
        int rdy_cnt = 0;
        slave_idle();
        bvalid = 1;
        request(1'b1, 32'hC000_0030, 4'b1111, 32'h0BAD_F00D);
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (awvalid) awv_cnt++;
            if (bvalid && bready) b_hs++;
            if (dready) rdy_cnt++;
            if (c == 2) begin
                if ({awvalid, wvalid} !== 2'b10) begin
                    failures++; $display("FAIL ws_w_dropped got=%b exp=10", {awvalid, wvalid});
                end
                checks++;
            end
            if (c == 6) begin
                if (dready !== 1'b1) begin
                    failures++; $display("FAIL ws_ready_c6 got=%b exp=1", dready);
                end
                checks++;
            end
            wready  = (c == 1);
            awready = (c == 4);
        end
        if (awv_cnt !== 4) begin
            failures++; $display("FAIL ws_awvalid_cycles got=%0d exp=4", awv_cnt);
        end
        checks++;
        if (b_hs !== 1 || rdy_cnt !== 1) begin
            failures++; $display("FAIL ws_single_b got=%0d/%0d exp=1/1", b_hs, rdy_cnt);
        end
        checks++;
        if (err !== 1'b0) begin
            failures++; $display("FAIL ws_err got=%b exp=0", err);
        end
        checks++;
        slave_idle();
    endtask

    task automatic test_read_slverr();
        slave_idle();
        arready = 1; rvalid = 1; rresp = 2'b10; rdata = 32'hDEAD_BEEF;
        request(1'b0, 32'hC000_0040, 4'b0000, 32'h0);
        tick(); tick(); tick();
        if ({dready, err} !== 2'b11 || dout !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL slverr_resp got=%b/%h exp=11/deadbeef", {dready, err}, dout);
        end
        checks++;
        rresp = 2'b00; rdata = 32'hCAFE_F00D;
        tick();
        request(1'b0, 32'hC000_0044, 4'b0000, 32'h0);
        tick(); tick(); tick();
        if ({dready, err} !== 2'b11 || dout !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL slverr_sticky got=%b/%h exp=11/cafef00d", {dready, err}, dout);
        end
        checks++;
        slave_idle();
        awready = 1; wready = 1; bvalid = 1;
        tick();
        request(1'b1, 32'hC000_0048, 4'b1111, 32'h1234_5678);
        tick(); tick(); tick();
        if (dready !== 1'b1 || dout !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL write_keeps_data got=%b/%h exp=1/cafef00d", dready, dout);
        end
        checks++;
        slave_idle();
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        if (err !== 1'b0) begin
            failures++; $display("FAIL to_err_cleared got=%b exp=0", err);
        end
        checks++;
        slave_idle();
        arready = 1; rvalid = 1; rdata = 32'h5555_AAAA;
        request(1'b0, 32'hC000_0050, 4'b0000, 32'h0);
        tick(); tick(); tick();
        if (dout !== 32'h5555_AAAA) begin
            failures++; $display("FAIL to_preload got=%h exp=5555aaaa", dout);
        end
        checks++;
        slave_idle();
        tick();
        request(1'b0, 32'hC000_0054, 4'b0000, 32'h0);
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c == 16) begin
                if ({arvalid, dready, err} !== 3'b100) begin
                    failures++; $display("FAIL to_c16 got=%b exp=100", {arvalid, dready, err});
                end
                checks++;
            end
        end
        if ({arvalid, dready, err} !== 3'b011 || dout !== 32'h0) begin
            failures++; $display("FAIL to_c17 got=%b/%h exp=011/00000000", {arvalid, dready, err}, dout);
        end
        checks++;
        tick();
    endtask

    task automatic test_strobe_drop_reset();
        int rdy_cnt = 0;
        do_reset();
        slave_idle();
        arready = 1;
        rdata = 32'h7777_0001;
        request(1'b0, 32'hC000_0060, 4'b0000, 32'h0);
        tick(); tick();  // N+2: RD_DATA
        request(1'b1, 32'hC000_0070, 4'b1111, 32'hFFFF_FFFF);
        tick();          // N+3
        if ({err, rready, awvalid, dready} !== 4'b1100) begin
            failures++; $display("FAIL drop_strobe got=%b exp=1100", {err, rready, awvalid, dready});
        end
        checks++;
        rvalid = 1;
        tick();          // N+4
        if (dready !== 1'b1 || dout !== 32'h7777_0001) begin
            failures++; $display("FAIL drop_read_done got=%b/%h exp=1/77770001", dready, dout);
        end
        checks++;
        slave_idle();
        tick();
        request(1'b1, 32'hC000_0080, 4'b1111, 32'h8888_0002);
        tick();
        if (awvalid !== 1'b1) begin
            failures++; $display("FAIL rst_wr_started got=%b exp=1", awvalid);
        end
        checks++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if ({awvalid, wvalid, bready, arvalid, rready, dready, err} !== 7'b0 || dout !== 32'h0 || awaddr !== 32'h0) begin
            failures++; $display("FAIL rst_mid_wr got=%b/%h/%h exp=0000000/0/0", {awvalid, wvalid, bready, arvalid, rready, dready, err}, dout, awaddr);
        end
        checks++;
        awready = 1; wready = 1; bvalid = 1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (dready || awvalid) rdy_cnt++;
        end
        if (rdy_cnt !== 0) begin
            failures++; $display("FAIL rst_no_pulse got=%0d exp=0", rdy_cnt);
        end
        checks++;
        slave_idle();
    endtask

    initial begin
        rst = 1'b1; strobe = 1'b0; addr = '0; rw = 1'b0; be = '0; wdat = '0;
        slave_idle();
        #1;
        test_reset();
        test_write_fast();
        test_read_delay();
        test_write_split();
        test_read_slverr();
        test_timeout();
        test_strobe_drop_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/device_axil_bridge.md
DEVICE_AXIL_BRIDGE -- requirements
Module: device_axil_bridge

Interface
REQ-001 Parameter XLEN, default 32, data/address width in bits.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, maximum cycles from command acceptance to completion; minimum value 4.
REQ-003 Port clk_i, in, 1: single clock; all logic on its rising edge.
REQ-004 Port rst_i, in, 1: reset, synchronous, active-high.
REQ-005 Port S_DEVICE_strobe_i, in, 1: one-cycle request pulse from the core-side device port.
REQ-006 Port S_DEVICE_addr_i, in, XLEN: request byte address.
REQ-007 Port S_DEVICE_rw_i, in, 1: 1 = write, 0 = read.
REQ-008 Port S_DEVICE_byte_enable_i, in, XLEN/8: write byte lanes.
REQ-009 Port S_DEVICE_data_i, in, XLEN: write data.
REQ-010 Port S_DEVICE_data_ready_o, out, 1: one-cycle completion pulse.
REQ-011 Port S_DEVICE_data_o, out, XLEN: read data, valid with data_ready_o.
REQ-012 Ports m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: AXI4-Lite master channels; awaddr, araddr, wdata and rdata are XLEN wide, wstrb is XLEN/8 wide, and bresp and rresp are 2 bits wide.
REQ-013 Port err_o, out, 1: sticky error flag (SLVERR/DECERR response, timeout, or strobe while busy).

Function
REQ-014 The bridge SHALL implement states IDLE, WR (AW/W outstanding), WR_RESP, RD_ADDR, RD_DATA and DONE.
REQ-015 In IDLE, a strobe SHALL latch addr, rw, byte_enable and data, and SHALL move to WR if rw=1 or RD_ADDR if rw=0.
REQ-016 In WR, awvalid and wvalid SHALL be asserted from the cycle after the strobe. Each SHALL deassert independently after its own handshake. The bridge SHALL move to WR_RESP once both handshakes are complete, whether they occur in the same cycle or in different cycles.
REQ-017 In WR_RESP, bready SHALL be high; on bvalid the bridge SHALL move to DONE, and a nonzero bresp SHALL set err_o.
REQ-018 In RD_ADDR, arvalid SHALL be high until arready, after which the bridge SHALL move to RD_DATA.
REQ-019 In RD_DATA, rready SHALL be high; on rvalid the bridge SHALL register rdata into S_DEVICE_data_o and move to DONE, and a nonzero rresp SHALL set err_o.
REQ-020 In DONE, S_DEVICE_data_ready_o SHALL be high for exactly one cycle, after which the bridge SHALL return to IDLE.
REQ-021 Minimum latency SHALL be strobe at cycle N with ready at N+3 when all AXI ready/valid signals respond immediately; ready SHALL never occur earlier than N+2.
REQ-022 All AXI outputs and S_DEVICE outputs SHALL be registered, with no combinational path from any input to any output.
REQ-023 awaddr/araddr SHALL carry the latched address unmodified, wstrb SHALL equal the latched byte_enable, and valid signals SHALL stay stable until their handshake.
REQ-024 A strobe in any state other than IDLE SHALL be dropped (no queueing) and SHALL set err_o.
REQ-025 A 16-bit-or-wider cycle counter SHALL clear on acceptance and increment each non-IDLE cycle.
REQ-026 On reaching TIMEOUT_CYCLES, the bridge SHALL deassert all valid/ready outputs, force S_DEVICE_data_o to 0, set err_o, and go to DONE.
REQ-027 S_DEVICE_data_o SHALL hold its last value outside DONE, and writes SHALL leave it unchanged.
REQ-028 err_o SHALL clear only on reset.

Reset
REQ-029 While rst_i is high, the state SHALL be IDLE and all valid/ready outputs, S_DEVICE_data_ready_o, err_o, S_DEVICE_data_o and the counter SHALL be 0.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction, and no data_ready_o pulse SHALL be issued for it.

Structure
REQ-031 AXI response codes (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11) and the FSM state encoding SHALL reside in a shared package, aquila_axi_pkg.
REQ-032 The bridge SHALL be a single module with no sub-modules; it sits directly downstream of the processor top's M_DEVICE port.

Verification
REQ-033 Write 0xC000_0010, data 0xA5A5_1234, byte_enable 4'b0011, with an immediately ready slave: the bench SHALL see awaddr=0xC000_0010, wstrb=0011, data_ready_o at N+3, and err_o=0.
REQ-034 Read 0xC000_0020 with the slave returning rdata 0x1122_3344 after a 5-cycle arready delay: the bench SHALL see arvalid held for 6 cycles, then data_o=0x1122_3344 with the ready pulse.
REQ-035 A write with wready 3 cycles before awready: the bench SHALL see wvalid drop after its handshake, awvalid held, and a single b handshake.
REQ-036 A read with rresp=SLVERR: the bench SHALL see the ready pulse, the data returned, err_o=1 sticky, and the next OKAY transaction leaving err_o=1.
REQ-037 A slave that never asserts arready with TIMEOUT_CYCLES=16: the bench SHALL see arvalid drop, data_o=0, the ready pulse at acceptance+17 cycles, and err_o=1.
REQ-038 A second strobe during RD_DATA, then rst_i pulsed during the following WR: the bench SHALL see the second strobe dropped with err_o=1, no ready pulse, and all outputs 0 in the cycle after reset.
